board_renderer: RTL and testbench
=================================

Name: board_renderer

Overview:
- Display-side reader of the game board state. Consumes serialized_board, select_loc and legal_move from the game FSM and renders the checkerboard on a 640x480@60 VGA raster.
- Sits between game_logic and the VGA DAC pins.
- Latches a frame-consistent snapshot of its inputs, generates sync timing and produces a 2-stage pipelined pixel colour.

Parameters:
- SQ_PX, 48, square edge in pixels
- ORG_X, 128, screen x of board column 0 left edge
- ORG_Y, 48, screen y of board row 7 top edge
- PIECE_R2, 324, squared piece radius (18 px)
- KING_R2, 36, squared king-dot radius (6 px)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_en  in  1  pixel-rate enable (25 MHz strobe); all state advances only when high
- serialized_board  in  192  cell i at [3i+2:3i], i={x[2:0],y[2:0]}; bit2 present, bit1 red, bit0 king
- select_loc  in  6  cursor square {x,y}
- legal_move  in  28  four fields at [6:0],[13:7],[20:14],[27:21], each {valid, loc[5:0]}
- vga_r  out  4  red
- vga_g  out  4  green
- vga_b  out  4  blue
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_de  out  1  visible-pixel flag
- frame_start  out  1  one-clk pulse when snapshot loads

Behaviour:
- Reset values: hcnt=0, vcnt=0, snapshot regs=0, vga_rgb=0, vga_hs=1, vga_vs=1, vga_de=0, frame_start=0. Reset mid-frame aborts the frame and restarts at (0,0) on the first pix_en after release.
- Horizontal timing: total 800.
  - visible 0-639
  - front porch 640-655
  - sync 656-751
  - back porch 752-799
- Vertical timing: total 525.
  - visible 0-479
  - front porch 480-489
  - sync 490-491
  - back porch 492-524
- Counters: hcnt wraps 799->0 and increments vcnt; vcnt wraps 524->0.
- Snapshot: on pix_en with hcnt=799 and vcnt=524, board, select_loc and legal_move are loaded into shadow registers and frame_start pulses for that clk. Input changes at any other time have no visible effect until the next load.
- Pipeline, stage A (pix_en):
  - compute in_board: 128<=h<512 and 48<=v<432.
  - col = (h-ORG_X)/SQ_PX; row = 7-(v-ORG_Y)/SQ_PX.
  - dx, dy = pixel offset inside the square (0..47).
  - Register raw hs, vs and de.
  - Implement the divisions with comparator chains or counters; no generic divider.
- Pipeline, stage B (pix_en): look up the snapshot cell {col,row} and register the final RGB, hs, vs and de.
- Latency: outputs reflect the counter value 2 pix_en cycles earlier, and syncs are delayed identically.
- Distance: d2 = (dx-24)^2 + (dy-24)^2, computed as a 12-bit unsigned value.
- Colour priority, highest first (12-bit RGB):
  - !de or !in_board: 000
  - king && present && d2<KING_R2: FC0
  - present && d2<PIECE_R2: red ? F00 : FFF
  - square==select_loc && (dx<2 || dx>45 || dy<2 || dy>45): FF0
  - square equals any valid legal_move loc: 0A0
  - (col+row) even: 630; else DB9
- All four legal_move fields are compared in parallel. Invalid fields are ignored even if loc matches. Duplicate matches are harmless.
- pix_en low: counters, pipeline and outputs hold. frame_start remains a single clk pulse.

Decomposition:
- Package checker_pkg:
  - H/V timing constants
  - cell bit indices (CELL_PRESENT=2, CELL_RED=1, CELL_KING=0)
  - legal_move field width 7
  - colour constants
  - the board cell typedef, shared with game_logic
- Sub-module vga_timing: counters, raw hs/vs/de, end-of-frame strobe.

Test Plan:
- Reset: rst=1 for 2 clks, pix_en=1 -> rgb=0, hs=vs=1, de=0; first hs fall occurs 656+2 pix_en cycles after release.
- Timing: free-run 2 frames -> hs period 800, hs low for 96, vs low for 1600 pix cycles, frame_start every 420000 pix cycles.
- Render: board cell {1,1}=100, {6,6}=111 loaded at frame start:
  - pixel (200,360) -> FFF
  - pixel (440,120) -> FC0
  - pixel (452,120) -> F00
  - pixel (150,50), empty square {0,7} where 0+7 is odd -> DB9
  - pixel (100,100) -> 000
- Snapshot: set cell {1,1}=000 at vcnt=200 -> pixel (200,360) stays FFF that frame and becomes 630 the next frame.
- Cursor/legal: select_loc={1,1}, legal_move[6:0]={1,{2,2}}, other fields valid=0 with loc={3,3}:
  - pixel (176,340) -> FF0
  - pixel (248,312) -> 0A0
  - square {3,3} pixel (296,264) -> 630
- Gating: pix_en=0 for 100 clks mid-line -> all outputs and counters constant. Resume continues from the same hcnt.

Source files
------------

// File: rtl/checker_pkg.sv
// rtl/checker_pkg.sv - shared board/raster constants, cell type and square divider
package checker_pkg;
    localparam int H_VIS    = 640;
    localparam int H_SYNC_S = 656;
    localparam int H_SYNC_E = 752;
    localparam int H_TOTAL  = 800;
    localparam int V_VIS    = 480;
    localparam int V_SYNC_S = 490;
    localparam int V_SYNC_E = 492;
    localparam int V_TOTAL  = 525;

    localparam int CELL_PRESENT = 2;
    localparam int CELL_RED     = 1;
    localparam int CELL_KING    = 0;
    localparam int LM_W         = 7;

    localparam logic [11:0] RGB_BLACK  = 12'h000;
    localparam logic [11:0] RGB_KING   = 12'hFC0;
    localparam logic [11:0] RGB_RED    = 12'hF00;
    localparam logic [11:0] RGB_WHITE  = 12'hFFF;
    localparam logic [11:0] RGB_CURSOR = 12'hFF0;
    localparam logic [11:0] RGB_LEGAL  = 12'h0A0;
    localparam logic [11:0] RGB_DARK   = 12'h630;
    localparam logic [11:0] RGB_LIGHT  = 12'hDB9;

    typedef logic [2:0] cell_t;

    typedef struct packed {
        logic [2:0] q;
        logic [5:0] r;
    } div_t;

    // Quotient by constant comparator chain; only valid for n < 8*sq.
    function automatic div_t div_sq(input logic [8:0] n, input int sq);
        div_t res;
        res.q = '0;
        for (int k = 1; k < 8; k++)
            if (int'(n) >= k * sq) res.q = 3'(k);
        res.r = 6'(int'(n) - int'(res.q) * sq);
        return res;
    endfunction
endpackage

// File: rtl/board_renderer_if.sv
// rtl/board_renderer_if.sv - game-state inputs and VGA pin outputs of the renderer
interface board_renderer_if;
    logic         pix_en;
    logic [191:0] serialized_board;
    logic [5:0]   select_loc;
    logic [27:0]  legal_move;
    logic [3:0]   vga_r;
    logic [3:0]   vga_g;
    logic [3:0]   vga_b;
    logic         vga_hs;
    logic         vga_vs;
    logic         vga_de;
    logic         frame_start;

    modport master (
        output pix_en, serialized_board, select_loc, legal_move,
        input  vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start
    );
    modport slave (
        input  pix_en, serialized_board, select_loc, legal_move,
        output vga_r, vga_g, vga_b, vga_hs, vga_vs, vga_de, frame_start
    );
endinterface

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 640x480 raster counters, raw syncs and end-of-frame strobe
module vga_timing
    import checker_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_pix_en,
    output logic [9:0] o_hcnt,
    output logic [9:0] o_vcnt,
    output logic       o_hs_raw,
    output logic       o_vs_raw,
    output logic       o_de_raw,
    output logic       o_eof
);
    logic [9:0] r_hcnt;
    logic [9:0] r_vcnt;
    logic       w_h_end;
    logic       w_v_end;

    assign w_h_end = (r_hcnt == 10'(H_TOTAL - 1));
    assign w_v_end = (r_vcnt == 10'(V_TOTAL - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_pix_en) begin
            if (w_h_end) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_end ? 10'd0 : r_vcnt + 10'd1;
            end else begin
                r_hcnt <= r_hcnt + 10'd1;
            end
        end
    end

    assign o_hcnt   = r_hcnt;
    assign o_vcnt   = r_vcnt;
    assign o_hs_raw = !(r_hcnt >= 10'(H_SYNC_S) && r_hcnt < 10'(H_SYNC_E));
    assign o_vs_raw = !(r_vcnt >= 10'(V_SYNC_S) && r_vcnt < 10'(V_SYNC_E));
    assign o_de_raw = (r_hcnt < 10'(H_VIS)) && (r_vcnt < 10'(V_VIS));
    assign o_eof    = i_pix_en && w_h_end && w_v_end && !rst;
endmodule

// File: rtl/board_renderer.sv
// rtl/board_renderer.sv - frame-snapshotted checkerboard renderer with 2-stage pixel pipeline
module board_renderer
    import checker_pkg::*;
#(
    parameter int SQ_PX    = 48,
    parameter int ORG_X    = 128,
    parameter int ORG_Y    = 48,
    parameter int PIECE_R2 = 324,
    parameter int KING_R2  = 36
) (
    input  logic             clk,
    input  logic             rst,
    board_renderer_if.slave  bus
);
    logic [9:0] w_hcnt, w_vcnt;
    logic       w_hs_raw, w_vs_raw, w_de_raw, w_eof;

    vga_timing u_timing (
        .clk      (clk),
        .rst      (rst),
        .i_pix_en (bus.pix_en),
        .o_hcnt   (w_hcnt),
        .o_vcnt   (w_vcnt),
        .o_hs_raw (w_hs_raw),
        .o_vs_raw (w_vs_raw),
        .o_de_raw (w_de_raw),
        .o_eof    (w_eof)
    );

    cell_t [63:0]           r_board;
    logic [5:0]             r_sel;
    logic [3:0][LM_W-1:0]   r_legal;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_board <= '0;
            r_sel   <= '0;
            r_legal <= '0;
        end else if (w_eof) begin
            r_board <= bus.serialized_board;
            r_sel   <= bus.select_loc;
            r_legal <= bus.legal_move;
        end
    end

    // Offsets are 9-bit: inside the board both h and v are below 512.
    logic [8:0] w_hrel, w_vrel;
    logic       w_inb;
    div_t       w_hdiv, w_vdiv;

    assign w_hrel = w_hcnt[8:0] - 9'(ORG_X);
    assign w_vrel = w_vcnt[8:0] - 9'(ORG_Y);
    assign w_inb  = (w_hcnt >= 10'(ORG_X)) && (w_hcnt < 10'(ORG_X + 8 * SQ_PX)) &&
                    (w_vcnt >= 10'(ORG_Y)) && (w_vcnt < 10'(ORG_Y + 8 * SQ_PX));
    assign w_hdiv = div_sq(w_hrel, SQ_PX);
    assign w_vdiv = div_sq(w_vrel, SQ_PX);

    logic [2:0] r_a_col, r_a_row;
    logic [5:0] r_a_dx, r_a_dy;
    logic       r_a_inb, r_a_hs, r_a_vs, r_a_de;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_col <= '0;
            r_a_row <= '0;
            r_a_dx  <= '0;
            r_a_dy  <= '0;
            r_a_inb <= 1'b0;
            r_a_hs  <= 1'b1;
            r_a_vs  <= 1'b1;
            r_a_de  <= 1'b0;
        end else if (bus.pix_en) begin
            r_a_col <= w_hdiv.q;
            r_a_row <= 3'd7 - w_vdiv.q;
            r_a_dx  <= w_hdiv.r;
            r_a_dy  <= w_vdiv.r;
            r_a_inb <= w_inb;
            r_a_hs  <= w_hs_raw;
            r_a_vs  <= w_vs_raw;
            r_a_de  <= w_de_raw;
        end
    end

    logic [5:0]  w_sq;
    cell_t       w_cell;
    logic [11:0] w_ax, w_ay, w_d2;
    logic        w_border, w_legal_hit;
    logic [11:0] w_rgb;

    assign w_sq   = {r_a_col, r_a_row};
    assign w_cell = r_board[w_sq];
    assign w_ax   = (r_a_dx >= 6'(SQ_PX / 2)) ? {6'd0, r_a_dx - 6'(SQ_PX / 2)}
                                              : {6'd0, 6'(SQ_PX / 2) - r_a_dx};
    assign w_ay   = (r_a_dy >= 6'(SQ_PX / 2)) ? {6'd0, r_a_dy - 6'(SQ_PX / 2)}
                                              : {6'd0, 6'(SQ_PX / 2) - r_a_dy};
    assign w_d2   = w_ax * w_ax + w_ay * w_ay;
    assign w_border = (r_a_dx < 6'd2) || (r_a_dx > 6'(SQ_PX - 3)) ||
                      (r_a_dy < 6'd2) || (r_a_dy > 6'(SQ_PX - 3));

    always_comb begin
        w_legal_hit = 1'b0;
        for (int k = 0; k < 4; k++)
            if (r_legal[k][LM_W-1] && (r_legal[k][LM_W-2:0] == w_sq)) w_legal_hit = 1'b1;
    end

    always_comb begin
        w_rgb = RGB_BLACK;
        if (!r_a_de || !r_a_inb)
            w_rgb = RGB_BLACK;
        else if (w_cell[CELL_KING] && w_cell[CELL_PRESENT] && (w_d2 < 12'(KING_R2)))
            w_rgb = RGB_KING;
        else if (w_cell[CELL_PRESENT] && (w_d2 < 12'(PIECE_R2)))
            w_rgb = w_cell[CELL_RED] ? RGB_RED : RGB_WHITE;
        else if ((w_sq == r_sel) && w_border)
            w_rgb = RGB_CURSOR;
        else if (w_legal_hit)
            w_rgb = RGB_LEGAL;
        else
            w_rgb = (r_a_col[0] ^ r_a_row[0]) ? RGB_LIGHT : RGB_DARK;
    end

    logic [11:0] r_rgb;
    logic        r_hs, r_vs, r_de;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rgb <= '0;
            r_hs  <= 1'b1;
            r_vs  <= 1'b1;
            r_de  <= 1'b0;
        end else if (bus.pix_en) begin
            r_rgb <= w_rgb;
            r_hs  <= r_a_hs;
            r_vs  <= r_a_vs;
            r_de  <= r_a_de;
        end
    end

    assign bus.vga_r       = r_rgb[11:8];
    assign bus.vga_g       = r_rgb[7:4];
    assign bus.vga_b       = r_rgb[3:0];
    assign bus.vga_hs      = r_hs;
    assign bus.vga_vs      = r_vs;
    assign bus.vga_de      = r_de;
    assign bus.frame_start = w_eof;
endmodule

// File: tb/tb_board_renderer.sv
// tb/tb_board_renderer.sv - directed self-checking bench for board_renderer
module tb_board_renderer;
    logic clk = 1'b0;
    logic rst = 1'b1;

    board_renderer_if bus();
    board_renderer dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int tb_h = 0, tb_v = 0, tb_cnt = 0;

    // Reference raster position of the counters, stepped on the same pix_en edges.
    always @(posedge clk) begin
        if (rst) begin
            tb_h <= 0; tb_v <= 0; tb_cnt <= 0;
        end else if (bus.pix_en) begin
            tb_cnt <= tb_cnt + 1;
            if (tb_h == 799) begin
                tb_h <= 0;
                tb_v <= (tb_v == 524) ? 0 : tb_v + 1;
            end else begin
                tb_h <= tb_h + 1;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait expired, observed timeout expected event", tag);
    endtask

    // Leaves the bench at the negedge where the outputs show pixel (h,v).
    task automatic wait_out(input int h, input int v);
        int guard = 0;
        @(negedge clk);
        while (!(tb_h == h + 2 && tb_v == v) && guard < 450000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 450000) timeout($sformatf("wait_%0d_%0d", h, v));
    endtask

    function automatic logic [11:0] rgb();
        return {bus.vga_r, bus.vga_g, bus.vga_b};
    endfunction

    initial begin
        logic [191:0] brd;
        int c;
        int fs1;

        brd = '0;
        brd[29:27]   = 3'b100;
        brd[164:162] = 3'b111;
        bus.pix_en           = 1'b1;
        bus.serialized_board = brd;
        bus.select_loc       = 6'b001_001;
        bus.legal_move       = {7'h1b, 7'h1b, 7'h1b, 7'h52};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_outs", {rgb(), bus.vga_hs, bus.vga_vs, bus.vga_de, bus.frame_start}, 16'h000C);
        rst = 1'b0;

        c = 0;
        do begin @(negedge clk); c++; end while (bus.vga_hs !== 1'b0 && c < 2000);
        check("first_hs_fall", c, 658);
        c = 0;
        do begin @(negedge clk); c++; end while (bus.vga_hs !== 1'b1 && c < 2000);
        check("hs_low_len", c, 96);
        do begin @(negedge clk); c++; end while (bus.vga_hs !== 1'b0 && c < 2000);
        check("hs_period", c, 800);

        wait_out(200, 360);
        check("f0_snapshot_empty", rgb(), 12'h630);
        check("f0_visible_flags", {bus.vga_hs, bus.vga_vs, bus.vga_de}, 3'b111);

        wait_out(655, 360);
        bus.pix_en = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            check("gated_hold", {rgb(), bus.vga_hs, bus.vga_vs, bus.vga_de, bus.frame_start}, 16'h000C);
        end
        bus.pix_en = 1'b1;
        @(negedge clk);
        check("resume_hs_fall", bus.vga_hs, 1'b0);

        c = 0;
        while (bus.vga_vs !== 1'b0 && c < 450000) begin @(negedge clk); c++; end
        if (c >= 450000) timeout("vs_fall");
        c = 0;
        while (bus.vga_vs === 1'b0 && c < 5000) begin @(negedge clk); c++; end
        check("vs_low_len", c, 1600);

        c = 0;
        while (bus.frame_start !== 1'b1 && c < 450000) begin @(negedge clk); c++; end
        check("frame_start_pos", tb_cnt, 419999);
        fs1 = tb_cnt;
        @(negedge clk);
        check("frame_start_pulse", bus.frame_start, 1'b0);

        wait_out(150, 50);
        check("empty_odd_square", rgb(), 12'hDB9);
        wait_out(100, 100);
        check("off_board", rgb(), 12'h000);
        wait_out(440, 120);
        check("king_dot", rgb(), 12'hFC0);
        wait_out(452, 120);
        check("red_piece", rgb(), 12'hF00);
        wait_out(0, 200);
        brd[29:27] = 3'b000;
        bus.serialized_board = brd;
        wait_out(296, 264);
        check("invalid_legal_ignored", rgb(), 12'h630);
        wait_out(248, 312);
        check("legal_square", rgb(), 12'h0A0);
        wait_out(176, 340);
        check("cursor_border", rgb(), 12'hFF0);
        wait_out(200, 360);
        check("snapshot_holds", rgb(), 12'hFFF);

        c = 0;
        while (bus.frame_start !== 1'b1 && c < 450000) begin @(negedge clk); c++; end
        check("frame_period", tb_cnt - fs1, 420000);

        wait_out(200, 360);
        check("snapshot_next_frame", rgb(), 12'h630);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
